// File: rtl/l2_host_req_ctrl.sv
// rtl/l2_host_req_ctrl.sv - host tag allocator, read command issue and out-of-order line completion
// Optional perf counters: define L2_HOST_REQ_PERF_EN.
module l2_host_req_ctrl #(
    parameter int addr_width       = 64,
    parameter int cache_line       = 128,
    parameter int cache_line_width = $clog2(cache_line),
    parameter int nstrms           = 64,
    parameter int nstrms_width     = $clog2(nstrms),
    parameter int ntags            = 16,
    parameter int tag_width        = $clog2(ntags)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [nstrms_width-1:0] i_req_sid,
    input  logic [addr_width-1:0]   i_req_ea,
    output logic                    o_cmd_v,
    input  logic                    o_cmd_r,
    output logic [tag_width-1:0]    o_cmd_tag,
    output logic [addr_width-1:0]   o_cmd_ea,
    input  logic                    i_hrsp_v,
    input  logic [tag_width-1:0]    i_hrsp_tag,
    input  logic                    i_hrsp_half,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [nstrms_width-1:0] o_rsp_sid,
    output logic [tag_width:0]      o_outstanding,
    output logic                    o_err,
    output logic [31:0]             o_perf_ncmd,
    output logic [31:0]             o_perf_busy
);

    logic [ntags-1:0]        busy;
    logic [ntags-1:0]        half0;
    logic [ntags-1:0]        half1;
    logic [nstrms_width-1:0] sid_mem [ntags];

    logic                    cmd_v;
    logic [tag_width-1:0]    cmd_tag;
    logic [addr_width-1:0]   cmd_ea;

    logic [tag_width-1:0]    fifo_mem [ntags];
    logic [tag_width-1:0]    wr_ptr;
    logic [tag_width-1:0]    rd_ptr;
    logic [tag_width:0]      fifo_cnt;
    logic [tag_width:0]      outstanding;
    logic                    err;

    logic                    any_free;
    logic [tag_width-1:0]    alloc_tag;
    logic                    accept;
    logic                    cmd_fire;
    logic                    beat_seen;
    logic                    beat_ok;
    logic                    beat_done;
    logic                    pop;
    logic [tag_width-1:0]    head_tag;

    // Lowest-index free tag wins: scan from the top so the last hit is the lowest.
    always_comb begin
        alloc_tag = '0;
        for (int i = ntags - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_tag = tag_width'(i);
        end
    end

    assign any_free  = ~&busy;
    assign i_req_r   = reset && any_free && (!cmd_v || o_cmd_r);
    assign accept    = i_req_v && i_req_r;
    assign cmd_fire  = cmd_v && o_cmd_r;

    assign beat_seen = i_hrsp_half ? half1[i_hrsp_tag] : half0[i_hrsp_tag];
    assign beat_ok   = i_hrsp_v && busy[i_hrsp_tag] && !beat_seen;
    assign beat_done = beat_ok && (i_hrsp_half ? half0[i_hrsp_tag] : half1[i_hrsp_tag]);

    assign head_tag  = fifo_mem[rd_ptr];
    assign pop       = (fifo_cnt != '0) && o_rsp_r;

    // Allocate, beat and pop always target distinct tags, so per-bit updates never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= '0;
            half0 <= '0;
            half1 <= '0;
        end else begin
            if (beat_ok) begin
                if (i_hrsp_half) half1[i_hrsp_tag] <= 1'b1;
                else             half0[i_hrsp_tag] <= 1'b1;
            end
            if (accept) begin
                busy[alloc_tag]  <= 1'b1;
                half0[alloc_tag] <= 1'b0;
                half1[alloc_tag] <= 1'b0;
            end
            if (pop) busy[head_tag] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)    sid_mem[alloc_tag] <= i_req_sid;
        if (beat_done) fifo_mem[wr_ptr]   <= i_hrsp_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_v   <= 1'b0;
            cmd_tag <= '0;
            cmd_ea  <= '0;
        end else if (accept) begin
            cmd_v   <= 1'b1;
            cmd_tag <= alloc_tag;
            cmd_ea  <= {i_req_ea[addr_width-1:cache_line_width], {cache_line_width{1'b0}}};
        end else if (cmd_fire) begin
            cmd_v   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (beat_done) wr_ptr <= wr_ptr + tag_width'(1);
            if (pop)       rd_ptr <= rd_ptr + tag_width'(1);
            case ({beat_done, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (tag_width + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (tag_width + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + (tag_width + 1)'(1);
                2'b01:   outstanding <= outstanding - (tag_width + 1)'(1);
                default: outstanding <= outstanding;
            endcase
            if (i_hrsp_v && !beat_ok) err <= 1'b1;
        end
    end

`ifdef L2_HOST_REQ_PERF_EN
    logic [31:0] perf_ncmd;
    logic [31:0] perf_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ncmd <= '0;
            perf_busy <= '0;
        end else begin
            if (cmd_fire)            perf_ncmd <= perf_ncmd + 32'd1;
            if (outstanding != '0)   perf_busy <= perf_busy + 32'd1;
        end
    end

    assign o_perf_ncmd = perf_ncmd;
    assign o_perf_busy = perf_busy;
`else
    assign o_perf_ncmd = '0;
    assign o_perf_busy = '0;
`endif

    assign o_cmd_v       = cmd_v;
    assign o_cmd_tag     = cmd_tag;
    assign o_cmd_ea      = cmd_ea;
    assign o_rsp_v       = (fifo_cnt != '0);
    assign o_rsp_sid     = sid_mem[head_tag];
    assign o_outstanding = outstanding;
    assign o_err         = err;

endmodule
